// File: rtl/axi4_burst_sram_slave_if.sv
// AXI4 bus bundle between a requester (master) and the burst SRAM responder (slave).
interface axi4_burst_sram_slave_if;
   // Read address / data
   logic [31:0] araddr;
   logic        arvalid;
   logic        arready;
   logic [3:0]  arid;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic [31:0] rdata;
   logic        rvalid;
   logic        rready;
   logic [1:0]  rresp;
   logic        rlast;
   logic [3:0]  rid;
   // Write address / data / response
   logic [31:0] awaddr;
   logic        awvalid;
   logic        awready;
   logic [3:0]  awid;
   logic [7:0]  awlen;
   logic [2:0]  awsize;
   logic [1:0]  awburst;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wvalid;
   logic        wlast;
   logic        wready;
   logic        bvalid;
   logic        bready;
   logic [1:0]  bresp;
   logic [3:0]  bid;

   modport slave (
      input  araddr, arvalid, arid, arlen, arsize, arburst, rready,
      input  awaddr, awvalid, awid, awlen, awsize, awburst,
      input  wdata, wstrb, wvalid, wlast, bready,
      output arready, rdata, rvalid, rresp, rlast, rid,
      output awready, wready, bvalid, bresp, bid
   );

   modport master (
      output araddr, arvalid, arid, arlen, arsize, arburst, rready,
      output awaddr, awvalid, awid, awlen, awsize, awburst,
      output wdata, wstrb, wvalid, wlast, bready,
      input  arready, rdata, rvalid, rresp, rlast, rid,
      input  awready, wready, bvalid, bresp, bid
   );
endinterface

// File: rtl/axi4_burst_sram_slave.sv
// AXI4 responder backed by an on-chip 32-bit word array. Independent read and write
// FSMs, INCR and FIXED bursts, per-beat legality with SLVERR on bad beats.
module axi4_burst_sram_slave #(
   parameter int unsigned DEPTH = 1024,
   parameter logic [31:0] BASE  = 32'h8000_0000
) (
   input logic                    i_clock,
   input logic                    i_reset,
   axi4_burst_sram_slave_if.slave axi
);
   localparam int unsigned IdxW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [1:0]  RespOkay   = 2'b00;
   localparam logic [1:0]  RespSlverr = 2'b10;

   typedef enum logic [0:0] {RIdle, RData} r_state_e;
   typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;

   logic [31:0] mem [DEPTH];

   // Only 4-byte beats with FIXED or INCR bursts are legal.
   function automatic logic attr_bad(input logic [2:0] size, input logic [1:0] burst);
      return (size != 3'd2) || burst[1];
   endfunction

   function automatic logic [31:0] start_idx(input logic [31:0] addr);
      return (addr - BASE) >> 2;
   endfunction

   function automatic logic beat_bad(input logic bad_attr, input logic [31:0] idx);
      return bad_attr || (idx >= DEPTH);
   endfunction

   // ---------------- Read channel ----------------
   r_state_e    r_state_q, r_state_d;
   logic [3:0]  r_id_q, r_id_d;
   logic [7:0]  r_len_q, r_len_d;
   logic [7:0]  r_cnt_q, r_cnt_d;
   logic [31:0] r_idx_q, r_idx_d;
   logic        r_fixed_q, r_fixed_d;
   logic        r_attr_bad_q, r_attr_bad_d;
   logic [31:0] rdata_q, rdata_d;
   logic [1:0]  rresp_q, rresp_d;
   logic        rlast_q, rlast_d;
   logic        rvalid_q, rvalid_d;
   logic        r_load;

   // Read next-state: accept AR, then present beats, loading the next one on each handshake.
   always_comb begin
      r_state_d    = r_state_q;
      r_id_d       = r_id_q;
      r_len_d      = r_len_q;
      r_cnt_d      = r_cnt_q;
      r_idx_d      = r_idx_q;
      r_fixed_d    = r_fixed_q;
      r_attr_bad_d = r_attr_bad_q;
      rdata_d      = rdata_q;
      rresp_d      = rresp_q;
      rlast_d      = rlast_q;
      rvalid_d     = rvalid_q;
      r_load       = 1'b0;
      case (r_state_q)
         RIdle: begin
            if (axi.arvalid) begin
               r_id_d       = axi.arid;
               r_len_d      = axi.arlen;
               r_cnt_d      = 8'd0;
               r_idx_d      = start_idx(axi.araddr);
               r_fixed_d    = (axi.arburst == 2'b00);
               r_attr_bad_d = attr_bad(axi.arsize, axi.arburst);
               r_load       = 1'b1;
               rvalid_d     = 1'b1;
               rlast_d      = (axi.arlen == 8'd0);
               r_state_d    = RData;
            end
         end
         RData: begin
            if (axi.rready) begin
               if (rlast_q) begin
                  rvalid_d  = 1'b0;
                  rlast_d   = 1'b0;
                  r_state_d = RIdle;
               end else begin
                  r_cnt_d = r_cnt_q + 8'd1;
                  r_idx_d = r_fixed_q ? r_idx_q : r_idx_q + 32'd1;
                  r_load  = 1'b1;
                  rlast_d = ((r_cnt_q + 8'd1) == r_len_q);
               end
            end
         end
         default: r_state_d = RIdle;
      endcase
      // Asynchronous array read: a same-cycle write is not yet visible here.
      if (r_load) begin
         if (beat_bad(r_attr_bad_d, r_idx_d)) begin
            rdata_d = 32'd0;
            rresp_d = RespSlverr;
         end else begin
            rdata_d = mem[r_idx_d[IdxW-1:0]];
            rresp_d = RespOkay;
         end
      end
   end

   // Read FSM state and registered outputs.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state_q    <= RIdle;
         r_id_q       <= 4'd0;
         r_len_q      <= 8'd0;
         r_cnt_q      <= 8'd0;
         r_idx_q      <= 32'd0;
         r_fixed_q    <= 1'b0;
         r_attr_bad_q <= 1'b0;
         rdata_q      <= 32'd0;
         rresp_q      <= RespOkay;
         rlast_q      <= 1'b0;
         rvalid_q     <= 1'b0;
      end else begin
         r_state_q    <= r_state_d;
         r_id_q       <= r_id_d;
         r_len_q      <= r_len_d;
         r_cnt_q      <= r_cnt_d;
         r_idx_q      <= r_idx_d;
         r_fixed_q    <= r_fixed_d;
         r_attr_bad_q <= r_attr_bad_d;
         rdata_q      <= rdata_d;
         rresp_q      <= rresp_d;
         rlast_q      <= rlast_d;
         rvalid_q     <= rvalid_d;
      end
   end

   // ---------------- Write channel ----------------
   w_state_e    w_state_q, w_state_d;
   logic [3:0]  w_id_q, w_id_d;
   logic [7:0]  w_len_q, w_len_d;
   logic [7:0]  w_cnt_q, w_cnt_d;
   logic [31:0] w_idx_q, w_idx_d;
   logic        w_fixed_q, w_fixed_d;
   logic        w_attr_bad_q, w_attr_bad_d;
   logic        w_err_q, w_err_d;
   logic        wready_q, wready_d;
   logic        bvalid_q, bvalid_d;
   logic [1:0]  bresp_q, bresp_d;
   logic [3:0]  bid_q, bid_d;
   logic        w_beat_bad;
   logic        w_err_next;
   logic        mem_we;

   // Write next-state: accept AW, absorb beats until the first wlast, then respond.
   always_comb begin
      w_state_d    = w_state_q;
      w_id_d       = w_id_q;
      w_len_d      = w_len_q;
      w_cnt_d      = w_cnt_q;
      w_idx_d      = w_idx_q;
      w_fixed_d    = w_fixed_q;
      w_attr_bad_d = w_attr_bad_q;
      w_err_d      = w_err_q;
      wready_d     = wready_q;
      bvalid_d     = bvalid_q;
      bresp_d      = bresp_q;
      bid_d        = bid_q;
      w_beat_bad   = beat_bad(w_attr_bad_q, w_idx_q);
      w_err_next   = w_err_q;
      mem_we       = 1'b0;
      case (w_state_q)
         WIdle: begin
            if (axi.awvalid) begin
               w_id_d       = axi.awid;
               w_len_d      = axi.awlen;
               w_cnt_d      = 8'd0;
               w_idx_d      = start_idx(axi.awaddr);
               w_fixed_d    = (axi.awburst == 2'b00);
               w_attr_bad_d = attr_bad(axi.awsize, axi.awburst);
               w_err_d      = 1'b0;
               wready_d     = 1'b1;
               w_state_d    = WData;
            end
         end
         WData: begin
            if (axi.wvalid && wready_q) begin
               mem_we = !w_beat_bad;
               // Early wlast and missing wlast at the last counted beat are both errors.
               w_err_next = w_err_q || w_beat_bad ||
                            (axi.wlast ? (w_cnt_q != w_len_q) : (w_cnt_q == w_len_q));
               w_err_d = w_err_next;
               w_cnt_d = w_cnt_q + 8'd1;
               w_idx_d = w_fixed_q ? w_idx_q : w_idx_q + 32'd1;
               if (axi.wlast) begin
                  wready_d  = 1'b0;
                  bvalid_d  = 1'b1;
                  bresp_d   = w_err_next ? RespSlverr : RespOkay;
                  bid_d     = w_id_q;
                  w_state_d = WResp;
               end
            end
         end
         WResp: begin
            if (axi.bready) begin
               bvalid_d  = 1'b0;
               w_state_d = WIdle;
            end
         end
         default: w_state_d = WIdle;
      endcase
   end

   // Write FSM state and registered outputs.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         w_state_q    <= WIdle;
         w_id_q       <= 4'd0;
         w_len_q      <= 8'd0;
         w_cnt_q      <= 8'd0;
         w_idx_q      <= 32'd0;
         w_fixed_q    <= 1'b0;
         w_attr_bad_q <= 1'b0;
         w_err_q      <= 1'b0;
         wready_q     <= 1'b0;
         bvalid_q     <= 1'b0;
         bresp_q      <= RespOkay;
         bid_q        <= 4'd0;
      end else begin
         w_state_q    <= w_state_d;
         w_id_q       <= w_id_d;
         w_len_q      <= w_len_d;
         w_cnt_q      <= w_cnt_d;
         w_idx_q      <= w_idx_d;
         w_fixed_q    <= w_fixed_d;
         w_attr_bad_q <= w_attr_bad_d;
         w_err_q      <= w_err_d;
         wready_q     <= wready_d;
         bvalid_q     <= bvalid_d;
         bresp_q      <= bresp_d;
         bid_q        <= bid_d;
      end
   end

   // Byte-enabled array write; contents survive reset, but a beat seen during reset is dropped.
   always_ff @(posedge i_clock) begin
      if (mem_we && !i_reset) begin
         for (int b = 0; b < 4; b++) begin
            if (axi.wstrb[b]) begin
               mem[w_idx_q[IdxW-1:0]][8*b +: 8] <= axi.wdata[8*b +: 8];
            end
         end
      end
   end

   // Address ready is combinational so it drops with reset and rises right after release.
   assign axi.arready = (r_state_q == RIdle) && !i_reset;
   assign axi.awready = (w_state_q == WIdle) && !i_reset;
   assign axi.rdata   = rdata_q;
   assign axi.rresp   = rresp_q;
   assign axi.rlast   = rlast_q;
   assign axi.rvalid  = rvalid_q;
   assign axi.rid     = r_id_q;
   assign axi.wready  = wready_q;
   assign axi.bvalid  = bvalid_q;
   assign axi.bresp   = bresp_q;
   assign axi.bid     = bid_q;
endmodule
